// File: rtl/fft_pkg.sv
// Shared constants, bank/reader state types and the bit-reverse helper
// used by the FFT power/reorder stage.
package fft_pkg;

  localparam int FFT_N     = 256;
  localparam int FFT_LOG2N = $clog2(FFT_N);
  localparam int FFT_WIDTH = 12;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    READING = 2'd2
  } bank_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [15:0] bitrev(
    input logic [15:0] idx,
    input int          log2n
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < log2n) r[i] = idx[log2n-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_power_reorder_if.sv
// Stream bundle between the FFT output, the power/reorder stage
// and the mel filterbank consumer.
interface fft_power_reorder_if #(
  parameter int WIDTH = 12,
  parameter int LOG2N = 8
);

  logic                    di_en;
  logic signed [WIDTH-1:0] di_re;
  logic signed [WIDTH-1:0] di_im;
  logic                    do_en;
  logic [LOG2N-1:0]        do_idx;
  logic [2*WIDTH-1:0]      do_pow;
  logic                    do_last;
  logic                    ovf;

  modport master (
    output di_en, di_re, di_im,
    input  do_en, do_idx, do_pow, do_last, ovf
  );

  modport slave (
    input  di_en, di_re, di_im,
    output do_en, do_idx, do_pow, do_last, ovf
  );

endinterface

// File: rtl/fft_pow_ram.sv
// Simple dual-port power buffer: one write port, one registered
// read port, contents are not reset.
module fft_pow_ram #(
  parameter int AW = 9,
  parameter int DW = 24
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_power_reorder.sv
// |X|^2 of bit-reversed FFT output, reordered to natural order via ping-pong banks.
// FFT_POWER_ONESIDED_EN: emit bins 0..N/2 only.
module fft_power_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N     = FFT_N
) (
  input logic                clock,
  input logic                reset,
  fft_power_reorder_if.slave bus
);

  localparam int LOG2N = $clog2(N);
  localparam int DW    = 2 * WIDTH;
`ifdef FFT_POWER_ONESIDED_EN
  localparam int RD_LAST = N / 2;
`else
  localparam int RD_LAST = N - 1;
`endif
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] RD_END   = LOG2N'(RD_LAST);

  logic                    in_v_q;
  logic signed [WIDTH-1:0] in_re_q;
  logic signed [WIDTH-1:0] in_im_q;
  logic signed [DW-1:0]    re_x, im_x, re_sq, im_sq;
  logic [DW-1:0]           pow_d, pow_q;
  logic                    pow_v_q;
  logic [LOG2N-1:0]        wr_idx_q, wr_cnt, wr_rev;
  logic                    wbank, drop_q, wr_end, ram_we;

  bank_state_t             bank_st [2];
  rd_state_t               rd_st;
  logic                    rbank;
  logic [LOG2N-1:0]        raddr;
  logic                    iss_v, iss_bank, iss_end;
  logic [LOG2N-1:0]        iss_addr;
  logic [1:0]              full, avail;
  logic                    iss_v_q;
  logic [LOG2N-1:0]        iss_idx_q;
  logic [DW-1:0]           rdata;

  assign re_x  = {{WIDTH{in_re_q[WIDTH-1]}}, in_re_q};
  assign im_x  = {{WIDTH{in_im_q[WIDTH-1]}}, in_im_q};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;
  assign pow_d = $unsigned(re_sq) + $unsigned(im_sq);

  always_ff @(posedge clock) begin
    if (reset) begin
      in_v_q   <= 1'b0;
      in_re_q  <= '0;
      in_im_q  <= '0;
      pow_v_q  <= 1'b0;
      pow_q    <= '0;
      wr_idx_q <= '0;
      wr_cnt   <= '0;
    end else begin
      in_v_q  <= bus.di_en;
      pow_v_q <= in_v_q;
      if (bus.di_en) begin
        in_re_q <= bus.di_re;
        in_im_q <= bus.di_im;
      end
      if (in_v_q) begin
        pow_q    <= pow_d;
        wr_idx_q <= wr_cnt;
        wr_cnt   <= wr_cnt + 1'b1;
      end
    end
  end

  assign wr_rev = LOG2N'(bitrev(16'(wr_idx_q), LOG2N));
  assign wr_end = pow_v_q && (wr_idx_q == LAST_IDX);
  assign ram_we = pow_v_q && !drop_q;

  assign full = {bank_st[1] == FULL, bank_st[0] == FULL};

  // An idle reader issues address 0 in the same cycle it sees a FULL bank.
  always_comb begin
    iss_v    = 1'b0;
    iss_bank = rbank;
    iss_addr = raddr;
    unique case (1'b1)
      rd_st == READ: iss_v = 1'b1;
      rd_st == IDLE && |full: begin
        iss_v    = 1'b1;
        iss_bank = !full[0];
        iss_addr = '0;
      end
      default: ;
    endcase
  end

  assign iss_end = iss_v && (iss_addr == RD_END);

  // A bank released by the reader this edge counts as free for the writer.
  assign avail = {
    bank_st[1] == EMPTY || (iss_end && iss_bank),
    bank_st[0] == EMPTY || (iss_end && !iss_bank)
  };

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_st      <= IDLE;
      rbank      <= 1'b0;
      raddr      <= '0;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wbank      <= 1'b0;
      drop_q     <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      if (iss_v) begin
        if (iss_end) begin
          bank_st[iss_bank] <= EMPTY;
          if (full[~iss_bank]) begin
            rd_st              <= READ;
            rbank              <= ~iss_bank;
            raddr              <= '0;
            bank_st[~iss_bank] <= READING;
          end else begin
            rd_st <= IDLE;
          end
        end else begin
          rd_st             <= READ;
          rbank             <= iss_bank;
          raddr             <= iss_addr + 1'b1;
          bank_st[iss_bank] <= READING;
        end
      end
      if (wr_end) begin
        if (!drop_q) bank_st[wbank] <= FULL;
        if (drop_q) bus.ovf <= 1'b1;
        if (avail[~wbank]) begin
          wbank  <= ~wbank;
          drop_q <= 1'b0;
        end else if (drop_q && avail[wbank]) begin
          drop_q <= 1'b0;
        end else begin
          drop_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      iss_v_q     <= 1'b0;
      iss_idx_q   <= '0;
      bus.do_en   <= 1'b0;
      bus.do_idx  <= '0;
      bus.do_pow  <= '0;
      bus.do_last <= 1'b0;
    end else begin
      iss_v_q     <= iss_v;
      bus.do_en   <= iss_v_q;
      bus.do_last <= iss_v_q && (iss_idx_q == RD_END);
      if (iss_v) iss_idx_q <= iss_addr;
      if (iss_v_q) begin
        bus.do_idx <= iss_idx_q;
        bus.do_pow <= rdata;
      end
    end
  end

  fft_pow_ram #(
    .AW (LOG2N + 1),
    .DW (DW)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr ({wbank, wr_rev}),
    .wdata (pow_q),
    .re    (iss_v),
    .raddr ({iss_bank, iss_addr}),
    .rdata (rdata)
  );

endmodule
